multiplier_32b_rr_arb: RTL
==========================

# multiplier_32b_rr_arb

Round-robin arbiter and sequencer sharing one 32x32 -> 64-bit registered multiplier among NUM_REQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one operation per cycle to the external multiplier. It routes each 64-bit product back to the issuing requester with response backpressure, and stalls the multiplier via its hold behaviour while a product is not yet consumed. It sits between the accelerator's requester ports and the shared multiplier instance.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- IDW, $clog2(NUM_REQ), width of the requester id
- iClk  in  1  clock, all logic on rising edge
- iRst  in  1  synchronous, active-high reset
- iFlush  in  1  drop pending response, clear multiplier
- iReqValid  in  NUM_REQ  per-requester request valid
- oReqReady  out  NUM_REQ  per-requester accept (one-hot or zero)
- iReqData0  in  NUM_REQ*32  operand A, requester i at [32*i +: 32]
- iReqData1  in  NUM_REQ*32  operand B, same packing
- oRespValid  out  NUM_REQ  product valid, one-hot or zero
- iRespReady  in  NUM_REQ  per-requester response accept
- oRespData  out  64  product, shared by all requesters
- oRespId  out  IDW  id of requester owning oRespData
- oMulEn  out  1  multiplier enable (load new product)
- oMulClr  out  1  multiplier clear
- oMulData0  out  32  operand A to multiplier
- oMulData1  out  32  operand B to multiplier
- iMulData  in  64  multiplier registered product

## Operation
- State: rPtr (IDW bits, highest-priority requester), rRespValid, rRespId.
- accept = rRespValid && iRespReady[rRespId].
- slot_free = !rRespValid || accept.
- issue = !iFlush && slot_free && |iReqValid.
- Grant g: first i with iReqValid[i] set, scanning rPtr, rPtr+1, ... wrapping mod NUM_REQ.
- oReqReady[g] = issue; all other bits 0. Requester holds valid and data stable until ready.
- oMulEn = issue; oMulData0/1 = operands of g, muxed combinationally (don't-care when !issue).
- On issue: rPtr <= (g+1) mod NUM_REQ, rRespValid <= 1, rRespId <= g.
- On accept without issue: rRespValid <= 0.
- Without issue, oMulEn = 0 and the multiplier holds the unconsumed product.
- oRespValid[i] = rRespValid && (rRespId == i).
- oRespData = iMulData (passthrough); oRespId = rRespId.
- iFlush: oMulClr = 1, rRespValid <= 0, no issue and no accept that cycle, rPtr unchanged. The requester is not charged for a flushed product.
- Arithmetic is unsigned 32x32, full 64-bit result, no truncation.

## Timing
- Reset (iRst = 1 at an edge): rPtr = 0, rRespValid = 0, rRespId = 0, counters = 0.
- During reset cycles, oMulClr = 1 and oMulEn = 0.
- After reset, all outputs are 0 until the first request.
- Latency: request accepted at edge N -> oRespValid high from cycle N+1.
- Full throughput: one issue per cycle when responses are accepted in the same cycle they appear (accept and issue coincide).
- Backpressure: while oRespValid is high and iRespReady is low, oReqReady is all 0 and oRespData is stable.
- iRst has priority over iFlush; iFlush has priority over issue and accept.

## Configuration
- MULTIPLIER_RR_ARB_STAT_EN defined:
  - Adds oIssueCnt (out, 32) counting issued operations.
  - Adds oStallCnt (out, 32) counting cycles with rRespValid && !accept.
  - Both wrap at 2^32 and clear on iRst only.
- Undefined: neither port nor counter exists. Functional behaviour is otherwise identical.

## Test plan
- Single request: req1 sends 0xFFFFFFFF x 0xFFFFFFFF with iRespReady all 1 -> oReqReady[1] in the same cycle; next cycle oRespValid = 0b0010, oRespData = 0xFFFFFFFE00000001, oRespId = 1.
- Round robin: all 4 valid continuously with responses always ready -> grants 0,1,2,3,0,... one per cycle; each product delivered exactly one cycle after its grant.
- Backpressure: req2 is granted 3 x 5 and its iRespReady is held low 3 cycles -> oRespData stays 15; oReqReady is 0 for those cycles; on the ready cycle the next grant issues simultaneously; oStallCnt = 3 when the macro is defined.
- Flush: iFlush is asserted while a response is pending -> oMulClr = 1, oRespValid = 0 next cycle, no grant in the flush cycle, rPtr unchanged.
- Reset mid-operation: iRst asserted with a pending response and requests valid -> after the edge all outputs are 0; the first grant after release goes to requester 0.
- Skip idle: only requesters 3 and 1 valid with rPtr = 2 -> grant 3, then 1.

Source files
------------

// File: rtl/multiplier_32b_rr_arb.sv
// Round-robin arbiter sharing one registered 32x32->64 multiplier among NUM_REQ requesters.
// Optional statistics counters are enabled with `define MULTIPLIER_RR_ARB_STAT_EN.
module multiplier_32b_rr_arb #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
   input  logic                   iClk,
   input  logic                   iRst,
   input  logic                   iFlush,
   input  logic [NUM_REQ-1:0]     iReqValid,
   output logic [NUM_REQ-1:0]     oReqReady,
   input  logic [NUM_REQ*32-1:0]  iReqData0,
   input  logic [NUM_REQ*32-1:0]  iReqData1,
   output logic [NUM_REQ-1:0]     oRespValid,
   input  logic [NUM_REQ-1:0]     iRespReady,
   output logic [63:0]            oRespData,
   output logic [IDW-1:0]         oRespId,
   output logic                   oMulEn,
   output logic                   oMulClr,
   output logic [31:0]            oMulData0,
   output logic [31:0]            oMulData1,
   input  logic [63:0]            iMulData
`ifdef MULTIPLIER_RR_ARB_STAT_EN
   ,
   output logic [31:0]            oIssueCnt,
   output logic [31:0]            oStallCnt
`endif
);

   localparam logic [IDW:0]   NumReqW = (IDW+1)'(NUM_REQ);
   localparam logic [IDW-1:0] LastId  = IDW'(NUM_REQ - 1);

   logic [IDW-1:0] ptr_q, ptr_d;
   logic           resp_valid_q, resp_valid_d;
   logic [IDW-1:0] resp_id_q, resp_id_d;

   logic [NUM_REQ-1:0] rot_valid;
   logic [IDW-1:0]     first_off;
   logic [IDW:0]       grant_sum;
   logic [IDW-1:0]     grant;
   logic [IDW-1:0]     ptr_next;
   logic               accept;
   logic               slot_free;
   logic               issue;

   // Rotate requests so that bit 0 is the current highest-priority requester.
   always_comb begin
      rot_valid = NUM_REQ'({iReqValid, iReqValid} >> ptr_q);
      first_off = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot_valid[k]) begin
            first_off = IDW'(k);
         end
      end
      grant_sum = {1'b0, ptr_q} + {1'b0, first_off};
      if (grant_sum >= NumReqW) begin
         grant = IDW'(grant_sum - NumReqW);
      end else begin
         grant = IDW'(grant_sum);
      end
      ptr_next = (grant == LastId) ? '0 : grant + 1'b1;
   end

   always_comb begin
      accept    = resp_valid_q && iRespReady[resp_id_q] && !iFlush && !iRst;
      slot_free = !resp_valid_q || accept;
      issue     = !iRst && !iFlush && slot_free && (|iReqValid);
   end

   always_comb begin
      ptr_d        = ptr_q;
      resp_valid_d = resp_valid_q;
      resp_id_d    = resp_id_q;
      if (issue) begin
         ptr_d        = ptr_next;
         resp_valid_d = 1'b1;
         resp_id_d    = grant;
      end else if (accept || iFlush) begin
         resp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         ptr_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= '0;
      end else begin
         ptr_q        <= ptr_d;
         resp_valid_q <= resp_valid_d;
         resp_id_q    <= resp_id_d;
      end
   end

   always_comb begin
      oReqReady  = '0;
      oRespValid = '0;
      oMulData0  = '0;
      oMulData1  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (issue && (grant == IDW'(i))) begin
            oReqReady[i] = 1'b1;
            oMulData0    = iReqData0[32*i +: 32];
            oMulData1    = iReqData1[32*i +: 32];
         end
         if (resp_valid_q && (resp_id_q == IDW'(i))) begin
            oRespValid[i] = 1'b1;
         end
      end
   end

   // Without an enable the external multiplier holds the product still owed.
   assign oMulEn    = issue;
   assign oMulClr   = iRst || iFlush;
   assign oRespData = iMulData;
   assign oRespId   = resp_id_q;

`ifdef MULTIPLIER_RR_ARB_STAT_EN
   logic [31:0] issue_cnt_q, issue_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      issue_cnt_d = issue_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (issue) begin
         issue_cnt_d = issue_cnt_q + 32'd1;
      end
      if (resp_valid_q && !accept) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         issue_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         issue_cnt_q <= issue_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign oIssueCnt = issue_cnt_q;
   assign oStallCnt = stall_cnt_q;
`endif

endmodule
